// File: rtl/hazard_stall_ctrl.sv
// Load-use / jr-on-load / mul-div interlock for the 5-stage MIPS pipeline: drives PC/IF-ID hold, ID/EX bubble, IF-ID flush.
// Latency: hazard outputs are combinational, 0 cycles from inputs; md_busy is registered.
// Backpressure: stall holds PC and IF/ID while a bubble is injected; a taken branch in EX overrides every stall with a flush.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MemRd_EX,
  input  logic       RegWr_EX,
  input  logic [4:0] WrAddr_EX,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       UseRs_ID,
  input  logic       UseRt_ID,
  input  logic       Jr_ID,
  input  logic       MdUse_ID,
  input  logic       md_start_EX,
  input  logic       BrTaken_EX,
  output logic       stall_PC,
  output logic       stall_IFID,
  output logic       bubble_IDEX,
  output logic       flush_IFID,
  output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_md
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, JRWAIT = 1'b1} state_t;

  localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 1);

  state_t     state_q;
  logic [5:0] md_cnt_q;
  logic       md_busy_q;

  logic hit_rs, hit_rt, lu, jrld, mdh, stall;

  // Hazard detection; R0 is never a real destination so it never matches
  always_comb begin
    hit_rs = RegWr_EX && (WrAddr_EX != 5'd0) && (Rs_ID == WrAddr_EX);
    hit_rt = RegWr_EX && (WrAddr_EX != 5'd0) && (Rt_ID == WrAddr_EX);
    lu     = MemRd_EX && ((UseRs_ID && hit_rs) || (UseRt_ID && hit_rt));
    // jr on an ALU result is covered by the bypass; only a load needs waiting
    jrld   = Jr_ID && MemRd_EX && hit_rs;
    mdh    = MdUse_ID && (md_busy_q || md_start_EX);
    stall  = lu || jrld || mdh || (state_q == JRWAIT);
  end

  // Pipeline control outputs; a taken branch makes the ID instruction wrong-path, so flush instead of hold
  always_comb begin
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    bubble_IDEX = 1'b0;
    flush_IFID  = 1'b0;
    if (rst_n) begin
      if (BrTaken_EX) begin
        flush_IFID  = 1'b1;
        bubble_IDEX = 1'b1;
      end else if (stall) begin
        stall_PC    = 1'b1;
        stall_IFID  = 1'b1;
        bubble_IDEX = 1'b1;
      end
    end
  end

  assign md_busy = md_busy_q;

  // Control FSM: jr waits one extra cycle after a load so the data can be bypassed from MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    state_q <= (jrld && !BrTaken_EX) ? JRWAIT : IDLE;
        JRWAIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Mul/div occupancy: busy spans the counter values LATENCY-1 down to 0, i.e. exactly MD_LATENCY cycles.
  // A taken branch does not cancel it; a start while busy simply reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q  <= 6'd0;
      md_busy_q <= 1'b0;
    end else if (md_start_EX) begin
      md_cnt_q  <= MD_RELOAD;
      md_busy_q <= 1'b1;
    end else if (md_cnt_q != 6'd0) begin
      md_cnt_q  <= md_cnt_q - 6'd1;
    end else begin
      md_busy_q <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q, perf_md_q;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters for stall, flush and mul/div interlock cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_md_q    <= '0;
    end else begin
      if (stall && (perf_stall_q != '1))     perf_stall_q <= perf_stall_q + CNT_ONE;
      if (flush_IFID && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + CNT_ONE;
      if (mdh && (perf_md_q != '1))          perf_md_q    <= perf_md_q + CNT_ONE;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_md    = perf_md_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LATENCY=4.
// Outputs packed as {stall_PC, stall_IFID, bubble_IDEX, flush_IFID, md_busy}.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       MemRd_EX, RegWr_EX, UseRs_ID, UseRt_ID, Jr_ID, MdUse_ID, md_start_EX, BrTaken_EX;
  logic [4:0] WrAddr_EX, Rs_ID, Rt_ID;
  logic       stall_PC, stall_IFID, bubble_IDEX, flush_IFID, md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush, perf_md;
`endif

  int passed = 0;
  int total  = 0;

  wire [4:0] outs = {stall_PC, stall_IFID, bubble_IDEX, flush_IFID, md_busy};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRd_EX(MemRd_EX), .RegWr_EX(RegWr_EX), .WrAddr_EX(WrAddr_EX),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .Jr_ID(Jr_ID), .MdUse_ID(MdUse_ID), .md_start_EX(md_start_EX), .BrTaken_EX(BrTaken_EX),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .bubble_IDEX(bubble_IDEX),
    .flush_IFID(flush_IFID), .md_busy(md_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_md(perf_md)
`endif
  );

  task automatic clear_inputs();
    MemRd_EX = 0; RegWr_EX = 0; WrAddr_EX = 0; Rs_ID = 0; Rt_ID = 0;
    UseRs_ID = 0; UseRt_ID = 0; Jr_ID = 0; MdUse_ID = 0; md_start_EX = 0; BrTaken_EX = 0;
  endtask

  task automatic clear_ex();
    MemRd_EX = 0; RegWr_EX = 0; WrAddr_EX = 0; md_start_EX = 0; BrTaken_EX = 0;
  endtask

  task automatic load_ex(input logic [4:0] rd);
    MemRd_EX = 1; RegWr_EX = 1; WrAddr_EX = rd;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    load_ex(5'd8); Rs_ID = 8; UseRs_ID = 1; MdUse_ID = 1; md_start_EX = 1;
    #2;
    total++;
    if (outs !== 5'b00000) $display("FAIL reset_outs got %b exp %b", outs, 5'b00000); else passed++;
    clear_inputs();
    step();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL after_reset got %b exp %b", outs, 5'b00000); else passed++;
    step();
  endtask

  task automatic test_load_use();
    load_ex(5'd8); Rs_ID = 8; UseRs_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL lu_rs got %b exp %b", outs, 5'b11100); else passed++;
    step();
    clear_ex();
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL lu_release got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs(); load_ex(5'd8); Rs_ID = 3; Rt_ID = 8; UseRs_ID = 1; UseRt_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL lu_rt got %b exp %b", outs, 5'b11100); else passed++;
    step();
    clear_inputs(); load_ex(5'd8); Rs_ID = 8; UseRs_ID = 0;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL lu_rs_unused got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_no_stall();
    RegWr_EX = 1; WrAddr_EX = 8; Rs_ID = 8; UseRs_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL alu_bypass got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs(); load_ex(5'd0); Rs_ID = 0; UseRs_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL load_r0 got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs(); RegWr_EX = 1; WrAddr_EX = 8; Rs_ID = 8; Jr_ID = 1; UseRs_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL jr_alu got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_jr_load();
    load_ex(5'd31); Rs_ID = 31; Jr_ID = 1; UseRs_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL jrld_c1 got %b exp %b", outs, 5'b11100); else passed++;
    step();
    clear_ex();
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL jrld_c2 got %b exp %b", outs, 5'b11100); else passed++;
    step();
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL jrld_c3 got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_mul_div();
    md_start_EX = 1; MdUse_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL md_pulse got %b exp %b", outs, 5'b11100); else passed++;
    step();
    md_start_EX = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++;
      if (outs !== 5'b11101) $display("FAIL md_busy_c%0d got %b exp %b", i, outs, 5'b11101); else passed++;
      step();
    end
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL md_release got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_branch();
    load_ex(5'd8); Rs_ID = 8; UseRs_ID = 1; BrTaken_EX = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00110) $display("FAIL br_lu got %b exp %b", outs, 5'b00110); else passed++;
    step();
    clear_inputs(); load_ex(5'd31); Rs_ID = 31; Jr_ID = 1; UseRs_ID = 1; BrTaken_EX = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00110) $display("FAIL br_jrld got %b exp %b", outs, 5'b00110); else passed++;
    step();
    clear_ex();
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL br_jrld_idle got %b exp %b", outs, 5'b00000); else passed++;
    step();
    load_ex(5'd31);
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL jrwait_enter got %b exp %b", outs, 5'b11100); else passed++;
    step();
    clear_ex(); BrTaken_EX = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00110) $display("FAIL br_in_jrwait got %b exp %b", outs, 5'b00110); else passed++;
    step();
    BrTaken_EX = 0;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL br_jrwait_exit got %b exp %b", outs, 5'b00000); else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_lu_mdh_overlap();
    load_ex(5'd8); Rs_ID = 8; UseRs_ID = 1; MdUse_ID = 1; md_start_EX = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b11100) $display("FAIL lu_mdh got %b exp %b", outs, 5'b11100); else passed++;
    step();
    clear_inputs();
    @(negedge clk);
    total++;
    if (outs !== 5'b00001) $display("FAIL busy_no_use got %b exp %b", outs, 5'b00001); else passed++;
    repeat (4) step();
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL busy_drained got %b exp %b", outs, 5'b00000); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    md_start_EX = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL md_start_no_use got %b exp %b", outs, 5'b00000); else passed++;
    step();
    md_start_EX = 0; load_ex(5'd31); Rs_ID = 31; Jr_ID = 1; UseRs_ID = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b11101) $display("FAIL mid_jrld got %b exp %b", outs, 5'b11101); else passed++;
    step();
    clear_ex(); MdUse_ID = 1;
    #2 rst_n = 0;
    #1;
    total++;
    if (outs !== 5'b00000) $display("FAIL mid_reset_async got %b exp %b", outs, 5'b00000); else passed++;
    step();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (outs !== 5'b00000) $display("FAIL post_reset got %b exp %b", outs, 5'b00000); else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({perf_stall, perf_flush, perf_md} !== 96'd0)
      $display("FAIL perf_reset got %0d %0d %0d exp 0 0 0", perf_stall, perf_flush, perf_md);
    else passed++;
`endif
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_jr_load();
    test_mul_div();
    test_branch();
    test_lu_mdh_overlap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
